// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, enable stalls iteration without losing state.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in1,
  input  logic [WIDTH-1:0] data_in2,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Trial subtraction R - {0,D} done as R + ~{0,D} + 1; the MSB is the borrow.
  function automatic logic [WIDTH:0] trial_sub(input logic [WIDTH:0] r,
                                               input logic [WIDTH-1:0] d);
    return r + ~{1'b0, d} + {{WIDTH{1'b0}}, 1'b1};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_reg_q, q_reg_d;
  logic [WIDTH-1:0] d_reg_q, d_reg_d;
  logic [WIDTH:0]   r_reg_q, r_reg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   r_shift_s;
  logic [WIDTH-1:0] q_shift_s;
  logic [WIDTH:0]   trial_s;

  // Next-state, datapath and result-load logic.
  always_comb begin
    state_d       = state_q;
    q_reg_d       = q_reg_q;
    d_reg_d       = d_reg_q;
    r_reg_d       = r_reg_q;
    cnt_d         = cnt_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    r_shift_s     = {r_reg_q[WIDTH-1:0], q_reg_q[WIDTH-1]};
    q_shift_s     = {q_reg_q[WIDTH-2:0], 1'b0};
    trial_s       = trial_sub(r_shift_s, d_reg_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          q_reg_d = data_in1;
          d_reg_d = data_in2;
          r_reg_d = {(WIDTH + 1){1'b0}};
          cnt_d   = CNT_INIT;
          if (data_in2 == {WIDTH{1'b0}}) begin
            state_d       = S_DONE;
            quotient_d    = {WIDTH{1'b1}};
            remainder_d   = data_in1;
            div_by_zero_d = 1'b1;
          end else begin
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CALC: begin
        if (enable) begin
          if (!trial_s[WIDTH]) begin
            r_reg_d = trial_s;
            q_reg_d = {q_shift_s[WIDTH-1:1], 1'b1};
          end else begin
            r_reg_d = r_shift_s;
            q_reg_d = q_shift_s;
          end
          cnt_d = cnt_q - CNT_ONE;
          // Last iteration: publish the freshly computed Q and R.
          if (cnt_d == CNT_ZERO) begin
            state_d       = S_DONE;
            quotient_d    = q_reg_d;
            remainder_d   = r_reg_d[WIDTH-1:0];
            div_by_zero_d = 1'b0;
          end else begin
            state_d = S_CALC;
          end
        end else begin
          state_d = S_CALC;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      q_reg_q       <= {WIDTH{1'b0}};
      d_reg_q       <= {WIDTH{1'b0}};
      r_reg_q       <= {(WIDTH + 1){1'b0}};
      cnt_q         <= CNT_ZERO;
      quotient_q    <= {WIDTH{1'b0}};
      remainder_q   <= {WIDTH{1'b0}};
      div_by_zero_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      q_reg_q       <= q_reg_d;
      d_reg_q       <= d_reg_d;
      r_reg_q       <= r_reg_d;
      cnt_q         <= cnt_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle unsigned restoring divider. It is the inverse-direction arithmetic companion to the combinational add/subtract datapath: it computes quotient and remainder by repeated trial subtraction, one quotient bit per clock. It sits beside the adder in the arithmetic unit and is controlled by a start/busy/done handshake. An `enable` qualifier stalls iteration without losing state.

## Interface
- `WIDTH`, default 8: operand, quotient and remainder width in bits (≥2).

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a division; sampled only in IDLE.
- `enable`  in  1  iteration qualifier; low freezes CALC state.
- `data_in1`  in  WIDTH  dividend; sampled on the accepting edge.
- `data_in2`  in  WIDTH  divisor; sampled on the accepting edge.
- `quotient`  out  WIDTH  result quotient; registered.
- `remainder`  out  WIDTH  result remainder; registered.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse; results valid.
- `div_by_zero`  out  1  set with results when the divisor was 0.

## Operation
- States: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE, `start`=1 (accepting edge):
  - Latch `data_in1` into the Q register and `data_in2` into the D register.
  - Clear the partial remainder R (WIDTH+1 bits) and load the iteration counter with WIDTH.
  - If `data_in2`==0, go to DONE. Set `quotient` to all ones, `remainder` to `data_in1`, and `div_by_zero` to 1.
  - Otherwise go to CALC.
- IDLE, `start`=0: hold. Outputs keep the last result.
- CALC, per edge with `enable`=1:
  - R ← {R[WIDTH-1:0], Q[WIDTH-1]}.
  - Q ← Q<<1.
  - T = R − {1'b0, D}, computed WIDTH+1 wide as R + ~D + 1.
  - If T[WIDTH]==0: R ← T and Q[0] ← 1.
  - Decrement the counter.
  - When the counter reaches 0, load `quotient` ← Q, `remainder` ← R[WIDTH-1:0], `div_by_zero` ← 0, and go to DONE.
- CALC, `enable`=0: every register holds. The counter does not advance.
- DONE: `done`=1 for exactly this cycle, then go to IDLE unconditionally. `enable` is ignored in DONE.
- `start` in CALC or DONE is ignored. It is not queued. Operand inputs may change freely after the accepting edge.
- `quotient`, `remainder` and `div_by_zero` hold until the next result load. They are not cleared on return to IDLE.
- Boundary results:
  - Divisor 1 gives quotient = dividend, remainder 0.
  - Dividend < divisor gives quotient 0, remainder = dividend.
  - Dividend 0 with nonzero divisor gives 0 and 0.

## Timing
- Reset (`rst` high at an edge) forces IDLE and clears `quotient`, `remainder`, `busy`, `done`, `div_by_zero`, R, Q, D and the counter.
  - Reset overrides everything, including mid-CALC. The result of an aborted operation is never produced.
- Normal division, accepting edge k, `enable` held high:
  - `busy`=1 from edge k.
  - Iterations occur on edges k+1 … k+WIDTH.
  - Results load and `done`=1 after edge k+WIDTH.
  - `busy`=0 and `done`=0 after edge k+WIDTH+1.
- Each edge in CALC with `enable`=0 delays completion by exactly one cycle.
- Divide by zero, accepting edge k: results and `done`=1 after edge k. IDLE after edge k+1.
- Back-to-back operation: the earliest next accepting edge is the first edge with the block in IDLE.
  - This is k+WIDTH+2 for a normal division and k+2 for divide by zero.
- Throughput: one division per WIDTH+2 cycles.
- `start` held high continuously restarts from IDLE each time. This is legal.

## Test plan
- WIDTH=8, 100/7, `enable`=1:
  - `done` appears 8 cycles after the accepting edge.
  - `quotient`=14, `remainder`=2, `div_by_zero`=0.
  - `busy` is high for exactly 9 cycles.
- 255/1 gives q=255, r=0. 5/9 gives q=0, r=5. 0/3 gives q=0, r=0. 255/255 gives q=1, r=0.
- 42/0:
  - `done` after 1 cycle with q=255, r=42, `div_by_zero`=1.
  - A following 9/2 gives q=4, r=1 and clears `div_by_zero`.
- 200/13 with `enable` dropped low for 3 cycles mid-CALC:
  - `done` arrives 3 cycles late (11 cycles after accept).
  - Result is still q=15, r=5.
- 77/5 with `start` pulsed again during CALC carrying operands 9/3: the pulse is ignored and the result is q=15, r=2.
- `rst` asserted at iteration 4 of 100/7:
  - Next cycle shows all outputs 0 and `busy`=0.
  - No `done` pulse appears.
  - A subsequent 100/7 completes normally with q=14, r=2.
